// File: rtl/cordic_scheduler.sv
// Two-requester front end for a shared CORDIC pipeline: arbitrates between requesters,
// drains the pipeline before any mode change and tags each result with its origin.
module cordic_scheduler #(
    parameter int LATENCY = 16,
    parameter int BURST   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic signed [31:0] req0_x,
    input  logic signed [31:0] req0_y,
    input  logic signed [31:0] req0_angle,
    input  logic        [1:0]  req0_mode,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic signed [31:0] req1_x,
    input  logic signed [31:0] req1_y,
    input  logic signed [31:0] req1_angle,
    input  logic        [1:0]  req1_mode,
    output logic signed [31:0] cordic_x,
    output logic signed [31:0] cordic_y,
    output logic signed [31:0] cordic_angle,
    output logic        [1:0]  cordic_mode,
    input  logic signed [31:0] cordic_rx,
    input  logic signed [31:0] cordic_ry,
    input  logic signed [31:0] cordic_rangle,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic signed [31:0] rsp_x,
    output logic signed [31:0] rsp_y,
    output logic signed [31:0] rsp_angle,
    output logic               busy
);
    // One op can sit on cordic_* plus LATENCY tag stages, hence LATENCY+1 in flight at most.
    localparam int IW = $clog2(LATENCY + 2);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    logic [1:0]         r_cur_mode;
    logic [1:0]         r_tgt_mode;
    logic               r_rr;
    logic [BW-1:0]      r_burst;
    logic [IW-1:0]      r_inflight;
    logic               r_issue_valid;
    logic               r_issue_id;
    logic [LATENCY-1:0] r_tag_valid;
    logic [LATENCY-1:0] r_tag_id;

    logic [1:0] w_mode0, w_mode1, w_tgt;
    logic       w_mis0, w_mis1, w_limit, w_run;
    logic       w_elig0, w_elig1, w_gnt, w_gnt_id, w_other_mis, w_retire;

    // LINEAR has two encodings; fold 01 onto 00 before any comparison.
    assign w_mode0 = (req0_mode == 2'b01) ? 2'b00 : req0_mode;
    assign w_mode1 = (req1_mode == 2'b01) ? 2'b00 : req1_mode;

    assign w_mis0      = req0_valid && (w_mode0 != r_cur_mode);
    assign w_mis1      = req1_valid && (w_mode1 != r_cur_mode);
    assign w_limit     = (r_burst == BW'(BURST)) && (w_mis0 || w_mis1);
    assign w_run       = (r_state == S_RUN) && !reset;
    assign w_elig0     = w_run && req0_valid && !w_mis0 && !w_limit;
    assign w_elig1     = w_run && req1_valid && !w_mis1 && !w_limit;
    assign w_gnt       = w_elig0 || w_elig1;
    assign w_gnt_id    = (w_elig0 && w_elig1) ? r_rr : w_elig1;
    assign w_other_mis = w_gnt_id ? w_mis0 : w_mis1;
    assign w_tgt       = (w_mis0 && w_mis1) ? (r_rr ? w_mode1 : w_mode0)
                                            : (w_mis1 ? w_mode1 : w_mode0);
    assign w_retire    = r_tag_valid[LATENCY-1];

    assign req0_ready  = w_gnt && !w_gnt_id;
    assign req1_ready  = w_gnt && w_gnt_id;
    assign cordic_mode = r_cur_mode;
    assign rsp_valid   = w_retire;
    assign rsp_id      = r_tag_id[LATENCY-1];
    assign rsp_x       = cordic_rx;
    assign rsp_y       = cordic_ry;
    assign rsp_angle   = cordic_rangle;
    assign busy        = (r_inflight != '0) || (r_state == S_DRAIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_cur_mode    <= 2'b10;
            r_tgt_mode    <= 2'b10;
            r_rr          <= 1'b0;
            r_burst       <= '0;
            r_inflight    <= '0;
            // NOTE: the tag chain is control state, so every stage is reset; a stale valid bit
            // here would emit a response for an operation that no longer exists.
            r_issue_valid <= 1'b0;
            r_issue_id    <= 1'b0;
            r_tag_valid   <= '0;
            r_tag_id      <= '0;
            cordic_x      <= '0;
            cordic_y      <= '0;
            cordic_angle  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand side reads the
            // pre-edge value regardless of statement order.
            r_issue_valid <= w_gnt;
            r_issue_id    <= w_gnt_id;
            r_tag_valid   <= {r_tag_valid[LATENCY-2:0], r_issue_valid};
            r_tag_id      <= {r_tag_id[LATENCY-2:0], r_issue_id};

            if (w_gnt) begin
                cordic_x     <= w_gnt_id ? req1_x     : req0_x;
                cordic_y     <= w_gnt_id ? req1_y     : req0_y;
                cordic_angle <= w_gnt_id ? req1_angle : req0_angle;
                r_rr         <= ~w_gnt_id;
            end

            unique case ({w_gnt, w_retire})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: ;
            endcase

            // Streak only counts while the other side is actually being held off.
            r_burst <= (w_gnt && w_other_mis) ? r_burst + BW'(1) : '0;

            case (r_state)
                S_RUN: begin
                    if (!w_gnt && (w_mis0 || w_mis1)) begin
                        r_state    <= S_DRAIN;
                        r_tgt_mode <= w_tgt;
                    end
                end
                S_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_cur_mode <= r_tgt_mode;
                        r_state    <= S_RUN;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_scheduler.sv
// Self-checking bench for cordic_scheduler: directed scenarios plus a randomized run
// compared against a queue-based model of the scheduling rules.
module tb_cordic_scheduler;
    localparam int LATENCY = 16;
    localparam int BURST   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_x = '0, req0_y = '0, req0_angle = '0;
    logic [31:0] req1_x = '0, req1_y = '0, req1_angle = '0;
    logic [1:0]  req0_mode = 2'b10, req1_mode = 2'b10;
    logic [31:0] cordic_x, cordic_y, cordic_angle;
    logic [1:0]  cordic_mode;
    logic [31:0] cordic_rx, cordic_ry, cordic_rangle;
    logic        rsp_valid, rsp_id, busy;
    logic [31:0] rsp_x, rsp_y, rsp_angle;

    int n_tests = 0;
    int n_fail  = 0;

    cordic_scheduler #(.LATENCY(LATENCY), .BURST(BURST)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_angle(req0_angle), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_angle(req1_angle), .req1_mode(req1_mode),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_angle(cordic_angle),
        .cordic_mode(cordic_mode),
        .cordic_rx(cordic_rx), .cordic_ry(cordic_ry), .cordic_rangle(cordic_rangle),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .rsp_angle(rsp_angle), .busy(busy)
    );

    always #5 clock = ~clock;

    // Stand-in pipeline: a fixed LATENCY-cycle delay with a recognisable transform per lane.
    logic [31:0] pipe_x [LATENCY];
    logic [31:0] pipe_y [LATENCY];
    logic [31:0] pipe_a [LATENCY];
    always @(posedge clock) begin
        for (int i = LATENCY - 1; i > 0; i--) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
        pipe_x[0] <= cordic_x;
        pipe_y[0] <= cordic_y;
        pipe_a[0] <= cordic_angle;
    end
    assign cordic_rx     = pipe_x[LATENCY-1] + 32'd7;
    assign cordic_ry     = pipe_y[LATENCY-1] + 32'd11;
    assign cordic_rangle = pipe_a[LATENCY-1] - 32'd3;

    // Reference model: outstanding operations live in a queue tagged with the cycle their
    // response is due; the pipeline counts as busy while that queue is non-empty.
    typedef struct {
        bit          id;
        logic [31:0] x;
        int          due;
    } op_t;

    op_t         q[$];
    int          m_cyc, m_streak;
    logic [1:0]  m_mode, m_tgt;
    bit          m_drain, m_rr, m_gv, m_gid;
    bit          want0, want1, odd0, odd1;
    logic [1:0]  n0, n1;
    logic [31:0] m_cx;

    function automatic logic [1:0] norm(input logic [1:0] m);
        return (m == 2'b01) ? 2'b00 : m;
    endfunction

    always @* begin
        n0    = norm(req0_mode);
        n1    = norm(req1_mode);
        want0 = req0_valid && (n0 == m_mode);
        want1 = req1_valid && (n1 == m_mode);
        odd0  = req0_valid && (n0 != m_mode);
        odd1  = req1_valid && (n1 != m_mode);
        m_gv  = 1'b0;
        m_gid = 1'b0;
        if (!reset && !m_drain && !(m_streak >= BURST && (odd0 || odd1))) begin
            if (want0 && want1) begin m_gv = 1'b1; m_gid = m_rr; end
            else if (want0)     begin m_gv = 1'b1; m_gid = 1'b0; end
            else if (want1)     begin m_gv = 1'b1; m_gid = 1'b1; end
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            m_cyc = 0; m_streak = 0; m_mode = 2'b10; m_tgt = 2'b10;
            m_drain = 1'b0; m_rr = 1'b0; m_cx = '0;
        end else begin
            bit empty_now;
            empty_now = (q.size() == 0);
            if (q.size() > 0 && q[0].due == m_cyc) void'(q.pop_front());
            if (m_drain) begin
                if (empty_now) begin m_mode = m_tgt; m_drain = 1'b0; m_streak = 0; end
            end else if (m_gv) begin
                op_t o;
                o.id = m_gid;
                o.x  = m_gid ? req1_x : req0_x;
                o.due = m_cyc + LATENCY + 1;
                q.push_back(o);
                m_cx = o.x;
                m_streak = (m_gid ? odd0 : odd1) ? m_streak + 1 : 0;
                m_rr = !m_gid;
            end else begin
                m_streak = 0;
                if (odd0 || odd1) begin
                    m_drain = 1'b1;
                    m_tgt = (odd0 && odd1) ? (m_rr ? n1 : n0) : (odd1 ? n1 : n0);
                end
            end
            m_cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        req0_valid = 1'b1; req0_mode = 2'b10; reset = 1'b1;
        @(negedge clock);
        n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
        n_tests++; if ({cordic_x, cordic_y, cordic_angle} !== 96'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h %h want 0", cordic_x, cordic_y, cordic_angle); end
        n_tests++; if (cordic_mode !== 2'b10) begin n_fail++; $display("FAIL reset_mode: got %b want 10", cordic_mode); end
        n_tests++; if ({rsp_valid, rsp_id, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_busy: got %b want 000", {rsp_valid, rsp_id, busy}); end
        idle_inputs();
    endtask

    task automatic test_single_issue();
        int first_k, nvalid;
        do_reset();
        repeat (3) next_cycle();
        req0_valid = 1'b1; req0_mode = 2'b10; req0_x = 32'd1000; req0_y = '0; req0_angle = '0;
        @(negedge clock);
        n_tests++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_grant: got %b want 10", {req0_ready, req1_ready}); end
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (cordic_x !== 32'd1000) begin n_fail++; $display("FAIL single_cordic_x: got %0d want 1000", cordic_x); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        first_k = -1; nvalid = 0;
        for (int k = 1; k <= 24; k++) begin
            next_cycle();
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                nvalid++;
                n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_rsp_id: got %b want 0", rsp_id); end
                n_tests++; if ({rsp_x, rsp_y, rsp_angle} !== {32'd1007, 32'd11, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL single_rsp_data: got %h %h %h", rsp_x, rsp_y, rsp_angle); end
            end
        end
        n_tests++; if (first_k !== LATENCY || nvalid !== 1) begin n_fail++; $display("FAIL single_rsp_timing: got first=%0d count=%0d want first=%0d count=1", first_k, nvalid, LATENCY); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_arbitration();
        bit grants[$];
        bit rsps[$];
        logic [31:0] rx[$];
        do_reset();
        next_cycle();
        req0_valid = 1'b1; req0_mode = 2'b10; req0_x = 32'd111;
        req1_valid = 1'b1; req1_mode = 2'b10; req1_x = 32'd222;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            n_tests++; if ({req1_ready, req0_ready} !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL arb_grant_%0d: got r1r0=%b%b want id %0d", i, req1_ready, req0_ready, i % 2); end
            grants.push_back(req1_ready);
            next_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin rsps.push_back(rsp_id); rx.push_back(rsp_x); end
            next_cycle();
        end
        n_tests++; if (rsps.size() !== 12) begin n_fail++; $display("FAIL arb_rsp_count: got %0d want 12", rsps.size()); end
        for (int i = 0; i < 12 && i < rsps.size(); i++) begin
            n_tests++; if (rsps[i] !== grants[i] || rx[i] !== (grants[i] ? 32'd229 : 32'd118)) begin n_fail++; $display("FAIL arb_rsp_%0d: got id %b x %0d want id %b", i, rsps[i], rx[i], grants[i]); end
        end
    endtask

    task automatic test_mode_switch();
        bit granted;
        int n_wait, bad_busy, bad_mode;
        do_reset();
        next_cycle();
        req0_valid = 1'b1; req0_mode = 2'b10; req0_x = 32'd5;
        @(negedge clock);
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL switch_first_grant: got %b want 1", req0_ready); end
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_mode = 2'b11; req1_x = 32'd77;
        granted = 1'b0; n_wait = 0; bad_busy = 0; bad_mode = 0;
        for (int k = 0; k < 40 && !granted; k++) begin
            @(negedge clock);
            if (req1_ready === 1'b1) begin
                granted = 1'b1;
                n_tests++; if (cordic_mode !== 2'b11) begin n_fail++; $display("FAIL switch_mode_at_grant: got %b want 11", cordic_mode); end
                n_tests++; if (n_wait !== LATENCY + 2) begin n_fail++; $display("FAIL switch_wait: got %0d want %0d", n_wait, LATENCY + 2); end
            end else begin
                n_wait++;
                if (busy !== 1'b1) bad_busy++;
                if (cordic_mode !== 2'b10) bad_mode++;
            end
            next_cycle();
        end
        req1_valid = 1'b0;
        n_tests++; if (!granted) begin n_fail++; $display("FAIL switch_timeout: got no grant want grant within 40 cycles"); end
        n_tests++; if (bad_busy !== 0 || bad_mode !== 0) begin n_fail++; $display("FAIL switch_drain_state: got %0d busy-low and %0d early-mode cycles want 0", bad_busy, bad_mode); end
        @(negedge clock);
        n_tests++; if (cordic_x !== 32'd77 || cordic_mode !== 2'b11) begin n_fail++; $display("FAIL switch_issue: got x %0d mode %b want 77 11", cordic_x, cordic_mode); end
    endtask

    task automatic test_starvation();
        bit granted;
        int n0g;
        do_reset();
        next_cycle();
        req1_valid = 1'b1; req1_mode = 2'b00; req1_x = 32'd333;
        req0_valid = 1'b1; req0_mode = 2'b10; req0_x = 32'd444;
        granted = 1'b0; n0g = 0;
        for (int k = 0; k < 80 && !granted; k++) begin
            @(negedge clock);
            if (req0_ready === 1'b1) n0g++;
            if (req1_ready === 1'b1) begin
                granted = 1'b1;
                n_tests++; if (cordic_mode !== 2'b00) begin n_fail++; $display("FAIL starve_mode: got %b want 00", cordic_mode); end
            end
            next_cycle();
        end
        idle_inputs();
        n_tests++; if (!granted) begin n_fail++; $display("FAIL starve_timeout: got no req1 grant want grant within 80 cycles"); end
        n_tests++; if (n0g !== BURST) begin n_fail++; $display("FAIL starve_burst: got %0d req0 grants want %0d", n0g, BURST); end
    endtask

    task automatic test_mode01();
        for (int k = 0; k < 40 && busy === 1'b1; k++) next_cycle();
        n_tests++; if (busy !== 1'b0 || cordic_mode !== 2'b00) begin n_fail++; $display("FAIL mode01_setup: got busy %b mode %b want 0 00", busy, cordic_mode); end
        next_cycle();
        req0_valid = 1'b1; req0_mode = 2'b01; req0_x = 32'd555;
        @(negedge clock);
        n_tests++; if (req0_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mode01_grant: got ready %b busy %b want 1 0", req0_ready, busy); end
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (cordic_x !== 32'd555 || cordic_mode !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL mode01_issue: got x %0d mode %b busy %b want 555 00 1", cordic_x, cordic_mode, busy); end
    endtask

    task automatic test_reset_midflight();
        int ng, seen;
        do_reset();
        next_cycle();
        req0_valid = 1'b1; req0_mode = 2'b10;
        ng = 0;
        for (int k = 0; k < 5; k++) begin
            req0_x = 32'(k + 900);
            @(negedge clock);
            if (req0_ready === 1'b1) ng++;
            next_cycle();
        end
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        n_tests++; if (ng !== 5) begin n_fail++; $display("FAIL midreset_issued: got %0d want 5", ng); end
        n_tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_clear: got busy %b rsp %b want 0 0", busy, rsp_valid); end
        next_cycle();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0) seen++;
            next_cycle();
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_ghost_rsp: got %0d responses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        bit granted;
        int ng, nrsp, n_wait;
        do_reset();
        next_cycle();
        req0_valid = 1'b1; req0_mode = 2'b10;
        ng = 0; nrsp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (req0_ready === 1'b1) ng++;
            if (rsp_valid === 1'b1) nrsp++;
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_mode = 2'b11;
        granted = 1'b0; n_wait = 0;
        for (int k = 0; k < 60 && !granted; k++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) nrsp++;
            if (req1_ready === 1'b1) granted = 1'b1;
            else n_wait++;
            next_cycle();
        end
        req1_valid = 1'b0;
        n_tests++; if (ng !== 20) begin n_fail++; $display("FAIL b2b_grants: got %0d want 20", ng); end
        n_tests++; if (nrsp !== 20) begin n_fail++; $display("FAIL b2b_responses: got %0d want 20", nrsp); end
        n_tests++; if (!granted || n_wait !== LATENCY + 2) begin n_fail++; $display("FAIL b2b_drain_end: got granted %b wait %0d want 1 %0d", granted, n_wait, LATENCY + 2); end
    endtask

    task automatic test_random();
        logic [1:0] s0, s1;
        bit exp_rv;
        do_reset();
        s0 = 2'b10; s1 = 2'b10;
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            if ($urandom_range(0, 9) == 0) s0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) s1 = 2'($urandom_range(0, 3));
            req0_valid = ($urandom_range(0, 3) != 0); req0_mode = s0;
            req1_valid = ($urandom_range(0, 3) != 0); req1_mode = s1;
            req0_x = $urandom; req0_y = $urandom; req0_angle = $urandom;
            req1_x = $urandom; req1_y = $urandom; req1_angle = $urandom;
            @(negedge clock);
            exp_rv = (q.size() > 0) && (q[0].due == m_cyc);
            n_tests++; if ({req1_ready, req0_ready} !== {m_gv && m_gid, m_gv && !m_gid}) begin n_fail++; $display("FAIL rand_ready c%0d: got %b%b want %b%b", c, req1_ready, req0_ready, m_gv && m_gid, m_gv && !m_gid); end
            n_tests++; if (cordic_mode !== m_mode || cordic_x !== m_cx) begin n_fail++; $display("FAIL rand_issue c%0d: got mode %b x %h want %b %h", c, cordic_mode, cordic_x, m_mode, m_cx); end
            n_tests++; if (busy !== (q.size() != 0 || m_drain)) begin n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, q.size() != 0 || m_drain); end
            n_tests++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rv); end
            if (exp_rv) begin
                n_tests++; if (rsp_id !== q[0].id || rsp_x !== q[0].x + 32'd7) begin n_fail++; $display("FAIL rand_rsp c%0d: got id %b x %h want %b %h", c, rsp_id, rsp_x, q[0].id, q[0].x + 32'd7); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_issue();
        test_arbitration();
        test_mode_switch();
        test_starvation();
        test_mode01();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
